// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end.
// Owns the fetch PC, drives the instruction memory request/ready handshake
// and turns memory wait states, hazard stalls and branch/jump redirects into
// clean single-cycle write or flush commands for the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall/flush counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] Instruction_Out,
    output logic [31:0] PCI_Out,
    output logic        IFID_WriteEnable,
    output logic        IFID_Flush,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount,
`endif
    output logic [31:0] PC_Out
);

    typedef enum logic [1:0] {
        ST_START,
        ST_FETCH,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_holdInstr;
    logic [31:0] r_holdPci;

    logic [31:0] w_pcNext;
    logic [31:0] w_target;

    // Sequential PC and word-aligned redirect target (low two bits dropped).
    assign w_pcNext = PC_Out + PC_INC;
    assign w_target = RedirectTarget & ~32'h0000_0003;

    // Fetch FSM: Redirect beats Stall, Stall beats normal advance; strobes
    // default low so each write/flush lasts exactly one cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state          <= ST_START;
            PC_Out           <= RESET_PC;
            ImemAddr         <= RESET_PC;
            ImemReq          <= 1'b0;
            Instruction_Out  <= 32'd0;
            PCI_Out          <= 32'd0;
            IFID_WriteEnable <= 1'b0;
            IFID_Flush       <= 1'b0;
            r_holdInstr      <= 32'd0;
            r_holdPci        <= 32'd0;
        end else begin
            IFID_WriteEnable <= 1'b0;
            IFID_Flush       <= 1'b0;
            case (r_state)
                ST_START: begin
                    ImemReq  <= 1'b1;
                    ImemAddr <= PC_Out;
                    r_state  <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (Redirect) begin
                        PC_Out     <= w_target;
                        IFID_Flush <= 1'b1;
                        if (ImemReady) begin
                            ImemAddr <= w_target;
                        end else begin
                            // Outstanding request cannot be cancelled; wait it out.
                            r_state <= ST_DRAIN;
                        end
                    end else if (ImemReady) begin
                        if (Stall) begin
                            r_holdInstr <= ImemData;
                            r_holdPci   <= w_pcNext;
                            ImemReq     <= 1'b0;
                            r_state     <= ST_HOLD;
                        end else begin
                            Instruction_Out  <= ImemData;
                            PCI_Out          <= w_pcNext;
                            IFID_WriteEnable <= 1'b1;
                            PC_Out           <= w_pcNext;
                            ImemAddr         <= w_pcNext;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (Redirect) begin
                        PC_Out     <= w_target;
                        IFID_Flush <= 1'b1;
                    end
                    if (ImemReady) begin
                        // Stale word is dropped; the new request goes to the latest PC.
                        ImemAddr <= Redirect ? w_target : PC_Out;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (Redirect) begin
                        PC_Out     <= w_target;
                        ImemAddr   <= w_target;
                        ImemReq    <= 1'b1;
                        IFID_Flush <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else if (!Stall) begin
                        Instruction_Out  <= r_holdInstr;
                        PCI_Out          <= r_holdPci;
                        IFID_WriteEnable <= 1'b1;
                        PC_Out           <= w_pcNext;
                        ImemAddr         <= w_pcNext;
                        ImemReq          <= 1'b1;
                        r_state          <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_START;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: count registered strobes and cycles spent in HOLD.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            FetchCount  <= 32'd0;
            StallCycles <= 32'd0;
            FlushCount  <= 32'd0;
        end else begin
            FetchCount  <= FetchCount + {31'd0, IFID_WriteEnable};
            FlushCount  <= FlushCount + {31'd0, IFID_Flush};
            StallCycles <= StallCycles + {31'd0, (r_state == ST_HOLD)};
        end
    end
`endif

endmodule
